b205_ref_out_gen: RTL and testbench
===================================

Name: b205_ref_out_gen

Overview:
- Generates a reference output from the 40 MHz ref_clk. The output is either a PPS pulse train or a 10 MHz square wave.
- Its purpose is to drive a downstream radio's external reference input, or to loop back into this board's reference PLL.
- It is the transmit end of the PPS/10 MHz reference interface that the reference PLL consumes.
- Supports glitch-free mode switching, a one-shot PPS period trim through a valid/ready handshake, and a hard re-sync.

Parameters:
- REF_CLK_FREQ, 40_000_000: ref_clk cycles per nominal PPS period.
- TEN_MHZ_DIV, 4: ref_clk cycles per 10 MHz period. Must be even and >= 2.
- PPS_HIGH_CYCLES, 4_000_000: PPS high time in ref_clk cycles (100 ms). Must satisfy REF_CLK_FREQ - 32768 > PPS_HIGH_CYCLES.

Ports:
- ref_clk  in  1  40 MHz clock
- reset  in  1  synchronous, active-high
- enable  in  1  level; 1 = generate output
- mode  in  1  requested mode; 0 = PPS, 1 = 10 MHz
- sync_req  in  1  single-cycle pulse; restart the period immediately
- trim  in  16  signed PPS period offset, in ref_clk cycles
- trim_valid  in  1  trim offered
- trim_ready  out  1  trim slot free
- ref_out  out  1  reference output (registered)
- edge_strobe  out  1  1-cycle pulse coincident with each ref_out rising edge
- active_mode  out  1  mode currently being generated
- running  out  1  generator active
- pps_count  out  32  count of PPS rising edges generated

Behaviour:
- Reset values: ref_out=0, edge_strobe=0, active_mode=0, running=0, pps_count=0, trim_ready=1. Internal cnt=0 and no trim pending.
- Reset mid-operation aborts immediately. A pending trim is discarded.
- Counter: cnt is 26 bits. Effective period P:
  - TEN_MHZ_DIV in 10 MHz mode.
  - REF_CLK_FREQ + sign-extended trim_latched in PPS mode.
- cnt counts 0..P-1. The cycle where cnt would reach P-1 and wrap is the "boundary".
- Output is registered from next-state:
  - ref_out = 1 while next cnt < H, else 0.
  - H = TEN_MHZ_DIV/2 in 10 MHz mode; H = PPS_HIGH_CYCLES in PPS mode.
- edge_strobe = 1 exactly on the edge where cnt loads 0 while running.
- States:
  - IDLE: running=0, ref_out=0, cnt=0.
    - enable sampled 1 → RUN.
    - On that same edge: cnt=0, ref_out=1, edge_strobe=1, active_mode=mode, running=1.
    - Latency from enable=1 to ref_out=1 is 1 cycle.
  - RUN:
    - At each boundary, mode is re-sampled into active_mode. Mode changes never take effect mid-period, so no runt pulses.
    - If enable=0 at a boundary → STOP_DRAIN.
    - enable=0 mid-period has no effect until the boundary.
  - STOP_DRAIN: lasts one cycle; drives ref_out=0 and running=0, then → IDLE.
    - If enable is already 1 again in this cycle, go to RUN on the next edge as from IDLE.
- sync_req in RUN: the next edge forces cnt=0, ref_out=1, edge_strobe=1, and re-samples mode.
  - This happens regardless of position in the period, and takes priority over the boundary and over enable=0 for that edge.
  - sync_req in IDLE is ignored.
- Trim handshake:
  - Transfer occurs when trim_valid & trim_ready on an edge. Transfer latches trim_latched and sets trim_ready=0.
  - A pending trim is consumed on the next edge where cnt loads 0 in PPS mode (boundary or sync). That period uses P = REF_CLK_FREQ + trim.
  - trim_ready returns to 1 on the consuming edge. The following period reverts to trim=0.
  - A transfer on the same edge as a cnt-load applies to the period after it, not the one starting on that edge.
  - In 10 MHz mode a pending trim is consumed and discarded at the next cnt-load.
- pps_count increments by 1 on every edge_strobe while active_mode=0 (after update). It wraps at 2^32-1 → 0 and holds value across enable toggles.
- Width/arithmetic:
  - P is computed in 27-bit signed arithmetic.
  - The trim range of ±32768 is guaranteed by the parameter constraint above, so no clipping is needed.

Test Plan:
- Setup: REF_CLK_FREQ=1000, PPS_HIGH_CYCLES=100, TEN_MHZ_DIV=4 (small values to keep simulation short).
- enable=1, mode=0 for 3000 cycles → ref_out rises 1 cycle after enable, then every 1000 cycles; high 100 cycles each; pps_count=3; edge_strobe 1-cycle aligned to each rise.
- mode=1 from the start → ref_out pattern 1,1,0,0 repeating; pps_count stays 0.
- In PPS mode, change mode 0→1 at cnt=300 → PPS period completes to 1000 cycles; 10 MHz begins exactly at the boundary; active_mode flips on that edge; no pulse shorter than 2 cycles.
- Trim:
  - trim=+50 accepted mid-period → next period is 1050 cycles, the following one 1000.
  - trim=-20 offered on the boundary edge → period after next is 980 cycles.
  - trim_ready is low from acceptance until the consuming edge.
- sync_req pulse at cnt=500 in PPS → ref_out rises on the next edge; the subsequent period is a full 1000 cycles; pps_count +1.
- enable=0 at cnt=50 → output continues to the boundary, then ref_out=0 and running=0. reset asserted at cnt=10 → all outputs at reset values on the next edge and trim_ready=1.

Source files
------------

// File: rtl/b205_ref_out_gen.sv
// Reference output generator: a PPS pulse train or a 10 MHz square wave
// derived from ref_clk. Supports mode switching at period boundaries only,
// a one-shot PPS period trim via valid/ready, and an immediate re-sync.
module b205_ref_out_gen #(
  parameter int unsigned REF_CLK_FREQ    = 40_000_000,
  parameter int unsigned TEN_MHZ_DIV     = 4,
  parameter int unsigned PPS_HIGH_CYCLES = 4_000_000
) (
  input  logic        ref_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mode,
  input  logic        sync_req,
  input  logic [15:0] trim,
  input  logic        trim_valid,
  output logic        trim_ready,
  output logic        ref_out,
  output logic        edge_strobe,
  output logic        active_mode,
  output logic        running,
  output logic [31:0] pps_count
);

  localparam logic [26:0] PPS_PERIOD = 27'(REF_CLK_FREQ);
  localparam logic [25:0] TEN_LAST   = 26'(TEN_MHZ_DIV - 1);
  localparam logic [25:0] TEN_HIGH   = 26'(TEN_MHZ_DIV / 2);
  localparam logic [25:0] PPS_HIGH   = 26'(PPS_HIGH_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [25:0] cnt_q, cnt_d;
  logic        ref_out_q, ref_out_d;
  logic        strobe_q, strobe_d;
  logic        mode_q, mode_d;
  logic        running_q, running_d;
  logic [31:0] pps_q, pps_d;
  logic        pend_q, pend_d;
  logic [15:0] trim_lat_q, trim_lat_d;
  logic [15:0] cur_trim_q, cur_trim_d;

  logic        load;
  logic [26:0] pps_len;
  logic        at_boundary;
  logic [25:0] high_lim;

  // Current PPS period length; cur_trim_q only changes on a cnt-load, so
  // the length is stable for the whole period.
  assign pps_len     = PPS_PERIOD + {{11{cur_trim_q[15]}}, cur_trim_q};
  assign at_boundary = mode_q ? (cnt_q == TEN_LAST)
                              : ({1'b0, cnt_q} == (pps_len - 27'd1));

  // State register
  always_ff @(posedge ref_clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; load marks an edge where cnt restarts at 0.
  // sync_req outranks both the boundary and a pending stop.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (sync_req) begin
          load = 1'b1;
        end else if (at_boundary) begin
          if (enable) load    = 1'b1;
          else        state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (enable) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; outputs are registered from next state.
  always_comb begin
    mode_d     = load ? mode : mode_q;
    running_d  = (state_d == ST_RUN);
    if (load)           cnt_d = '0;
    else if (running_d) cnt_d = cnt_q + 26'd1;
    else                cnt_d = '0;
    high_lim   = mode_d ? TEN_HIGH : PPS_HIGH;
    ref_out_d  = running_d && (cnt_d < high_lim);
    strobe_d   = load;
    pps_d      = pps_q + {31'd0, load & ~mode_d};

    // Pending trim is consumed on every cnt-load; it only shapes the new
    // period when that period is PPS. A transfer is only possible while no
    // trim is pending, so it never collides with consumption.
    cur_trim_d = cur_trim_q;
    pend_d     = pend_q;
    trim_lat_d = trim_lat_q;
    if (load) begin
      cur_trim_d = (pend_q && !mode_d) ? trim_lat_q : '0;
      pend_d     = 1'b0;
    end
    if (trim_valid && !pend_q) begin
      pend_d     = 1'b1;
      trim_lat_d = trim;
    end
  end

  // Datapath registers
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      cnt_q      <= '0;
      ref_out_q  <= 1'b0;
      strobe_q   <= 1'b0;
      mode_q     <= 1'b0;
      running_q  <= 1'b0;
      pps_q      <= '0;
      pend_q     <= 1'b0;
      trim_lat_q <= '0;
      cur_trim_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ref_out_q  <= ref_out_d;
      strobe_q   <= strobe_d;
      mode_q     <= mode_d;
      running_q  <= running_d;
      pps_q      <= pps_d;
      pend_q     <= pend_d;
      trim_lat_q <= trim_lat_d;
      cur_trim_q <= cur_trim_d;
    end
  end

  assign trim_ready  = ~pend_q;
  assign ref_out     = ref_out_q;
  assign edge_strobe = strobe_q;
  assign active_mode = mode_q;
  assign running     = running_q;
  assign pps_count   = pps_q;

endmodule

// File: tb/tb_b205_ref_out_gen.sv
// Bench for b205_ref_out_gen: directed scenarios plus randomized stimulus,
// every cycle compared against a period-level behavioural model.
module tb_b205_ref_out_gen;

  localparam int RCF = 1000;
  localparam int PHC = 100;
  localparam int TMD = 4;

  logic        ref_clk = 1'b0;
  logic        reset, enable, mode, sync_req, trim_valid;
  logic [15:0] trim;
  logic        trim_ready, ref_out, edge_strobe, active_mode, running;
  logic [31:0] pps_count;

  always #5 ref_clk = ~ref_clk;

  b205_ref_out_gen #(
    .REF_CLK_FREQ(RCF),
    .TEN_MHZ_DIV(TMD),
    .PPS_HIGH_CYCLES(PHC)
  ) dut (
    .ref_clk(ref_clk),
    .reset(reset),
    .enable(enable),
    .mode(mode),
    .sync_req(sync_req),
    .trim(trim),
    .trim_valid(trim_valid),
    .trim_ready(trim_ready),
    .ref_out(ref_out),
    .edge_strobe(edge_strobe),
    .active_mode(active_mode),
    .running(running),
    .pps_count(pps_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Model: position within the current period and that period's length.
  bit          m_run;
  int          m_phase;
  int          m_len;
  bit          m_mode;
  bit          m_pend;
  int          m_trimv;
  logic [31:0] m_pps;
  bit          m_ref;
  bit          m_strobe;

  function automatic void model_step();
    bit start, stop, ready;
    start = 0;
    stop  = 0;
    ready = !m_pend;
    if (reset) begin
      m_run = 0; m_phase = 0; m_len = RCF; m_mode = 0; m_pend = 0;
      m_trimv = 0; m_pps = '0; m_ref = 0; m_strobe = 0;
      return;
    end
    if (m_run) begin
      if (sync_req) start = 1;
      else if (m_phase == m_len - 1) begin
        if (enable) start = 1;
        else        stop  = 1;
      end
    end else begin
      start = enable;
    end
    if (start) begin
      m_mode  = mode;
      m_len   = mode ? TMD : RCF + ((m_pend && !mode) ? m_trimv : 0);
      m_pend  = 0;
      m_phase = 0;
      m_run   = 1;
      if (!mode) m_pps = m_pps + 1;
    end else if (stop) begin
      m_run   = 0;
      m_phase = 0;
    end else if (m_run) begin
      m_phase++;
    end
    if (trim_valid && ready) begin
      m_pend  = 1;
      m_trimv = int'($signed(trim));
    end
    m_strobe = start;
    m_ref    = m_run && (m_phase < (m_mode ? TMD / 2 : PHC));
  endfunction

  task automatic cycle();
    @(posedge ref_clk);
    #1;
    model_step();
    check("ref_out",     ref_out,     m_ref);
    check("edge_strobe", edge_strobe, m_strobe);
    check("active_mode", active_mode, m_mode);
    check("running",     running,     m_run);
    check("trim_ready",  trim_ready,  !m_pend);
    check("pps_count",   pps_count,   m_pps);
  endtask

  task automatic wait_strobe(input int limit, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!edge_strobe && n < limit);
  endtask

  int          n;
  logic [31:0] p0;
  logic [7:0]  pat;

  initial begin
    reset = 1; enable = 0; mode = 0; sync_req = 0; trim_valid = 0; trim = '0;
    cycle();
    cycle();
    check("rst_ref_out", ref_out, 0);
    check("rst_strobe", edge_strobe, 0);
    check("rst_running", running, 0);
    check("rst_pps", pps_count, 0);
    check("rst_ready", trim_ready, 1);
    reset = 0;

    // PPS basic: rise one cycle after enable, three rises in 3000 cycles
    enable = 1;
    cycle();
    check("lat1_ref", ref_out, 1);
    check("lat1_strobe", edge_strobe, 1);
    repeat (2999) cycle();
    check("pps3", pps_count, 3);
    wait_strobe(5000, n);
    check("sync_pps", n, 1);

    // +50 trim accepted mid-period
    repeat (200) cycle();
    trim = 16'd50; trim_valid = 1;
    cycle();
    trim_valid = 0;
    check("trim50_busy", trim_ready, 0);
    wait_strobe(5000, n);
    check("trim50_rem", n, 799);
    check("trim50_free", trim_ready, 1);
    wait_strobe(5000, n);
    check("per_1050", n, 1050);
    wait_strobe(5000, n);
    check("per_after", n, 1000);

    // -20 trim offered on the boundary edge
    repeat (999) cycle();
    trim = 16'hFFEC; trim_valid = 1;
    cycle();
    trim_valid = 0;
    check("bnd_strobe", edge_strobe, 1);
    check("trim20_busy", trim_ready, 0);
    wait_strobe(5000, n);
    check("per_nexttrim", n, 1000);
    check("trim20_free", trim_ready, 1);
    wait_strobe(5000, n);
    check("per_980", n, 980);

    // Mode 0->1 at cnt=300 completes the PPS period
    repeat (300) cycle();
    p0 = pps_count;
    mode = 1;
    wait_strobe(5000, n);
    check("mode_rem", n, 700);
    check("mode_flip", active_mode, 1);
    pat = {7'd0, ref_out};
    repeat (7) begin
      cycle();
      pat = {pat[6:0], ref_out};
    end
    check("ten_pattern", pat, 8'b11001100);
    check("ten_pps", pps_count, p0);
    mode = 0;
    wait_strobe(5000, n);
    check("back_pps", active_mode, 0);

    // sync_req at cnt=500
    repeat (500) cycle();
    p0 = pps_count;
    sync_req = 1;
    cycle();
    sync_req = 0;
    check("sync_strobe", edge_strobe, 1);
    check("sync_ref", ref_out, 1);
    check("sync_pps", pps_count, p0 + 1);
    wait_strobe(5000, n);
    check("sync_per", n, 1000);

    // enable dropped at cnt=50 drains to the boundary
    repeat (50) cycle();
    enable = 0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (running && n < 5000);
    check("drain_len", n, 950);
    check("drain_ref", ref_out, 0);
    cycle();
    check("idle_run", running, 0);

    // Reset at cnt=10 with a trim pending discards it
    enable = 1;
    cycle();
    check("restart_ref", ref_out, 1);
    repeat (4) cycle();
    trim = 16'd7; trim_valid = 1;
    cycle();
    trim_valid = 0;
    check("pend_busy", trim_ready, 0);
    repeat (5) cycle();
    reset = 1;
    cycle();
    check("mrst_ref", ref_out, 0);
    check("mrst_run", running, 0);
    check("mrst_mode", active_mode, 0);
    check("mrst_pps", pps_count, 0);
    check("mrst_ready", trim_ready, 1);
    reset = 0;
    wait_strobe(5000, n);
    check("mrst_start", n, 1);
    wait_strobe(5000, n);
    check("mrst_per", n, 1000);

    // 10 MHz from the start
    reset = 1;
    cycle();
    reset = 0; mode = 1;
    cycle();
    pat = {7'd0, ref_out};
    repeat (7) begin
      cycle();
      pat = {pat[6:0], ref_out};
    end
    check("ten_start_pat", pat, 8'b11001100);
    repeat (32) cycle();
    check("ten_start_pps", pps_count, 0);

    // Randomized traffic
    enable = 1;
    for (int i = 0; i < 12000; i++) begin
      int t;
      reset = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 599) == 0) enable = ~enable;
      if ($urandom_range(0, 399) == 0) mode = ~mode;
      sync_req   = ($urandom_range(0, 499) == 0);
      trim_valid = ($urandom_range(0, 29) == 0);
      t    = int'($urandom_range(0, 400)) - 200;
      trim = 16'(t);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
